// File: rtl/square_root_engine.sv
// Iterative integer square root: one root bit per clock, start/ready/valid handshake.
// Define SQRT_ROUND_EN to round the root output to nearest; the remainder stays the floor remainder.
module square_root_engine #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned ROOT_WIDTH = WIDTH / 2
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      alpha,
    output logic                  ready,
    output logic                  valid,
    output logic [ROOT_WIDTH-1:0] root,
    output logic [ROOT_WIDTH:0]   remainder
);

    localparam int unsigned RW = ROOT_WIDTH;
    localparam int unsigned TW = RW + 3;
    localparam int unsigned CW = (RW > 1) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [RW-1:0]   wroot_q, wroot_d;
    logic [RW:0]     wrem_q, wrem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   root_q, root_d;
    logic [RW:0]     rem_q, rem_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;

    logic [1:0]      pair;
    logic [TW-1:0]   trial;
    logic [RW-1:0]   root_nx;
    logic [RW:0]     rem_nx;
    logic [RW-1:0]   root_out;

    // One digit-recurrence step on the current work registers.
    always_comb begin
        pair  = opnd_q[WIDTH-1 -: 2];
        trial = TW'({wrem_q, pair}) - TW'({wroot_q, 2'b01});
        if (trial[TW-1]) begin
            rem_nx  = (RW+1)'({wrem_q, pair});
            root_nx = RW'({wroot_q, 1'b0});
        end else begin
            rem_nx  = (RW+1)'(trial);
            root_nx = RW'({wroot_q, 1'b1});
        end
`ifdef SQRT_ROUND_EN
        // Round up when rem > root, i.e. alpha lies above (root+0.5)^2; saturate at all-ones.
        if ((rem_nx > {1'b0, root_nx}) && (root_nx != {RW{1'b1}}))
            root_out = root_nx + RW'(1);
        else
            root_out = root_nx;
`else
        root_out = root_nx;
`endif
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        wroot_d = wroot_q;
        wrem_d  = wrem_q;
        cnt_d   = cnt_q;
        root_d  = root_q;
        rem_d   = rem_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    opnd_d  = alpha;
                    wroot_d = '0;
                    wrem_d  = '0;
                    cnt_d   = CW'(RW - 1);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    opnd_d  = opnd_q << 2;
                    wroot_d = root_nx;
                    wrem_d  = rem_nx;
                    if (cnt_q == '0) begin
                        root_d  = root_out;
                        rem_d   = rem_nx;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            opnd_q  <= '0;
            wroot_q <= '0;
            wrem_q  <= '0;
            cnt_q   <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            wroot_q <= wroot_d;
            wrem_q  <= wrem_d;
            cnt_q   <= cnt_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign ready     = ready_q;
    assign valid     = valid_q;
    assign root      = root_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_square_root_engine.sv
// Scoreboard bench for square_root_engine: WIDTH=8 directed + exhaustive, plus a WIDTH=16 corner.
module tb_square_root_engine;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       start, abort;
    logic [7:0] alpha;
    logic       ready, valid;
    logic [3:0] root;
    logic [4:0] remainder;

    logic        start16, abort16;
    logic [15:0] alpha16;
    logic        ready16, valid16;
    logic [7:0]  root16;
    logic [8:0]  remainder16;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {int a; int fr; int r; int m;} exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    square_root_engine #(.WIDTH(8)) dut (
        .clock(clock), .clear_n(clear_n), .start(start), .abort(abort), .alpha(alpha),
        .ready(ready), .valid(valid), .root(root), .remainder(remainder)
    );

    square_root_engine #(.WIDTH(16)) dut16 (
        .clock(clock), .clear_n(clear_n), .start(start16), .abort(abort16), .alpha(alpha16),
        .ready(ready16), .valid(valid16), .root(root16), .remainder(remainder16)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: linear search for the floor root, then optional rounding.
    function automatic exp_t model(input int a, input int maxr);
        exp_t e;
        e.a = a;
        e.fr = 0;
        for (int i = 0; i <= maxr; i++) if (i * i <= a) e.fr = i;
        e.m = a - e.fr * e.fr;
        e.r = e.fr;
`ifdef SQRT_ROUND_EN
        if (e.m > e.fr && e.fr < maxr) e.r = e.fr + 1;
`endif
        return e;
    endfunction

    always @(negedge clock) begin
        if (clear_n && valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("root(a=%0d)", mon_e.a), int'(root), mon_e.r);
                check($sformatf("rem(a=%0d)", mon_e.a), int'(remainder), mon_e.m);
                check($sformatf("identity(a=%0d)", mon_e.a),
                      mon_e.fr * mon_e.fr + int'(remainder), mon_e.a);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 40) begin @(posedge clock); #1; n++; end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    // Issue one request with a scoreboard entry and wait for its valid pulse.
    task automatic run_op(input int a, input bit chk_lat);
        int lat = 0;
        wait_ready();
        start = 1'b1;
        alpha = 8'(a);
        exp_q.push_back(model(a, 15));
        @(posedge clock); #1;
        start = 1'b0;
        while (!valid && lat < 40) begin @(posedge clock); #1; lat++; end
        if (chk_lat) check("latency", lat, 4);
        @(posedge clock); #1;
        if (chk_lat) check("valid_one_cycle", int'(valid), 0);
    endtask

    initial begin
        int n;
        clear_n = 1'b0;
        start = 1'b0; abort = 1'b0; alpha = '0;
        start16 = 1'b0; abort16 = 1'b0; alpha16 = '0;
        #12;
        check("rst_ready", int'(ready), 1);
        check("rst_valid", int'(valid), 0);
        check("rst_root", int'(root), 0);
        check("rst_rem", int'(remainder), 0);
        clear_n = 1'b1;
        @(posedge clock); #1;

        run_op(0, 1'b1);
        run_op(144, 1'b1);
        run_op(255, 1'b1);
        run_op(13, 1'b1);
        run_op(12, 1'b1);

        // start and abort together in IDLE: request dropped
        start = 1'b1; abort = 1'b1; alpha = 8'd77;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_wins_ready", int'(ready), 1);

        // second start with alpha=99 mid-RUN is ignored
        start = 1'b1; alpha = 8'd13;
        exp_q.push_back(model(13, 15));
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        start = 1'b1; alpha = 8'd99;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("ignored_start_drained", exp_q.size(), 0);

        // abort mid-RUN: no valid, outputs hold the 13 result
        wait_ready();
        start = 1'b1; alpha = 8'd200;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("abort_ready", int'(ready), 1);
        repeat (6) @(posedge clock);
        #1;
        check("abort_root_held", int'(root), model(13, 15).r);
        check("abort_rem_held", int'(remainder), 4);

        // asynchronous clear mid-RUN
        start = 1'b1; alpha = 8'd255;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #3;
        clear_n = 1'b0;
        #1;
        check("clr_ready", int'(ready), 1);
        check("clr_valid", int'(valid), 0);
        check("clr_root", int'(root), 0);
        check("clr_rem", int'(remainder), 0);
        @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock); #1;
        run_op(144, 1'b1);

        for (int a = 0; a < 256; a++) run_op(a, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("sweep_drained", exp_q.size(), 0);

        // WIDTH=16 all-ones operand
        start16 = 1'b1; alpha16 = 16'hFFFF;
        @(posedge clock); #1;
        start16 = 1'b0;
        n = 0;
        while (!valid16 && n < 40) begin @(posedge clock); #1; n++; end
        check("w16_latency", n, 8);
        check("w16_root", int'(root16), 255);
        check("w16_rem", int'(remainder16), 510);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
